spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_controller_if.sv | 36 +++
 rtl/spi_clk_div.sv | 35 +++
 rtl/spi_controller.sv | 116 +++++++++++
 tb/tb_spi_controller.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// +------------------------------------------------------------------+
// | spi_pkg : shared SPI state encoding, defaults and mode constants |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_STOP  = 2'd3
    } spi_state_e;

    localparam int DEFAULT_CLK_DIV = 4;
    localparam int DEFAULT_DATA_W  = 8;

    // Mode 0, shared with the peripheral side.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

`default_nettype wire

// File: rtl/spi_controller_if.sv
// +------------------------------------------------------------------+
// | spi_controller_if : byte stream handshake plus SPI pins          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface spi_controller_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_last;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              ss;
    logic              busy;

    modport master (
        input  tx_data, tx_last, tx_valid, miso,
        output tx_ready, rx_data, rx_valid, sclk, mosi, ss, busy
    );

    modport slave (
        output tx_data, tx_last, tx_valid, miso,
        input  tx_ready, rx_data, rx_valid, sclk, mosi, ss, busy
    );
endinterface

`default_nettype wire

// File: rtl/spi_clk_div.sv
// +------------------------------------------------------------------+
// | spi_clk_div : half-period tick generator, counter held at 0      |
// |               while disabled                                     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en_i,
    output logic      tick_o
);
    localparam int                CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/spi_controller.sv
// +------------------------------------------------------------------+
// | spi_controller : mode-0 SPI master with byte stream handshake    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    spi_controller_if.master  bus
);
    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic              div_en_q, div_en_d;
    logic              ready_en_q;
    logic              sclk_q;
    logic              last_q;
    logic              rx_valid_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              tick;
    logic              tx_ready;
    logic              accept;
    logic              last_fall;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (div_en_q),
        .tick_o (tick)
    );

    // ready_en_q keeps tx_ready low until the first clock after reset release.
    assign tx_ready  = ready_en_q && ((state_q == ST_IDLE) || (state_q == ST_GAP));
    assign accept    = bus.tx_valid && tx_ready;
    assign last_fall = tick && sclk_q && (bit_cnt_q == LAST_BIT);

    assign bus.tx_ready = tx_ready;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.sclk     = sclk_q ^ SPI_CPOL;
    assign bus.mosi     = tx_shift_q[DATA_W-1];
    assign bus.ss       = !((state_q == ST_SHIFT) || (state_q == ST_GAP));
    assign bus.busy     = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            div_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_en_q <= div_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_GAP: if (accept)    state_d = ST_SHIFT;
            ST_SHIFT:        if (last_fall) state_d = last_q ? ST_STOP : ST_GAP;
            ST_STOP:         if (tick)      state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
        // The divider idles for the STOP entry cycle so ss stays high CLK_DIV more cycles.
        div_en_d = (state_d == ST_SHIFT) || ((state_q == ST_STOP) && (state_d == ST_STOP));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            sclk_q     <= 1'b0;
            last_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            rx_valid_q <= 1'b0;
            if (accept) begin
                tx_shift_q <= bus.tx_data;
                last_q     <= bus.tx_last;
                bit_cnt_q  <= '0;
                sclk_q     <= 1'b0;
            end else if ((state_q == ST_SHIFT) && tick) begin
                if (!sclk_q) begin
                    sclk_q     <= 1'b1;
                    rx_shift_q <= {rx_shift_q[DATA_W-2:0], bus.miso};
                end else begin
                    sclk_q <= 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                        bit_cnt_q  <= '0;
                    end else begin
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                        tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// +------------------------------------------------------------------+
// | tb_spi_controller : directed + randomized bench for spi_controller|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_spi_controller;
    import spi_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int DATA_W  = 8;
    localparam int FRAME   = 1 + 2 * DATA_W * CLK_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    spi_controller_if #(.DATA_W(DATA_W)) bus ();

    spi_controller #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Peripheral: loopback, or a mode-0 slave presenting periph_byte MSB first.
    logic       loop_en = 1'b1;
    logic [7:0] periph_byte = 8'h00;
    int         bit_idx = 0;
    always @(negedge bus.sclk) bit_idx++;
    assign bus.miso = loop_en ? bus.mosi : periph_byte[3'(7 - bit_idx)];

    int         rises = 0;
    int         rxv_cnt = 0;
    logic [7:0] mosi_cap = 8'h00;
    always @(posedge bus.sclk) begin
        rises++;
        mosi_cap = {mosi_cap[6:0], bus.mosi};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Half-period and mosi setup checker, sampled between clock edges.
    logic prev_sclk = 1'b0;
    logic prev_mosi = 1'b0;
    int   hlen = 0;
    int   stable = 0;
    int   rib = 0;
    always @(negedge clk) begin
        if (bus.rx_valid) rxv_cnt++;
        if (!rst_n) begin
            prev_sclk = 1'b0;
            prev_mosi = bus.mosi;
            hlen = 0;
            stable = 0;
            rib = 0;
        end else begin
            if (bus.sclk !== prev_sclk) begin
                if (prev_sclk) begin
                    check("half_high", hlen, CLK_DIV);
                end else begin
                    if (rib != 0) check("half_low", hlen, CLK_DIV);
                    check("mosi_setup", (stable >= CLK_DIV) && (bus.mosi === prev_mosi), 1);
                    rib++;
                end
                hlen = 1;
            end else begin
                hlen++;
            end
            if (bus.mosi === prev_mosi) stable++;
            else stable = 1;
            prev_mosi = bus.mosi;
            prev_sclk = bus.sclk;
            if (bus.rx_valid) rib = 0;
        end
    end

    task automatic xfer(input logic [7:0] d, input logic last, input logic hold);
        int         n;
        int         ss_hi;
        logic       mand;
        logic [7:0] exp_rx;
        exp_rx = loop_en ? d : periph_byte;
        bus.tx_data  = d;
        bus.tx_last  = last;
        bus.tx_valid = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", bus.tx_ready, 1);
        bit_idx = 0;
        @(posedge clk); #1;
        if (!hold) bus.tx_valid = 1'b0;
        check("ss_cyc1", bus.ss, 0);
        check("mosi_cyc1", bus.mosi, d[7]);
        check("busy_cyc1", bus.busy, 1);
        n = 1;
        ss_hi = 0;
        mand = 1'b1;
        while (!bus.rx_valid && n < 200) begin
            mand = mand & bus.mosi;
            if (bus.ss) ss_hi++;
            if (hold) begin
                check("no_accept", bus.tx_ready, 0);
                bus.tx_data = 8'($urandom);
                bus.tx_last = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        if (hold) bus.tx_valid = 1'b0;
        check("rx_latency", n, FRAME);
        check("rx_data", bus.rx_data, exp_rx);
        check("mosi_bits", mosi_cap, d);
        check("ss_in_frame", ss_hi, 0);
        check("sclk_end", bus.sclk, 0);
        check("ss_end", bus.ss, last);
        if (d == 8'hFF) check("mosi_const", mand, 1);
        if (last) begin
            @(posedge clk); #1;
            n++;
            check("rx_pulse", bus.rx_valid, 0);
            while (!bus.tx_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check("ready_back", n, FRAME + 3);
            check("idle_ss", bus.ss, 1);
        end
    endtask

    initial begin
        int n;
        int nb;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b0;
        #2;
        check("rst_ss", bus.ss, 1);
        check("rst_sclk", bus.sclk, 0);
        check("rst_mosi", bus.mosi, 0);
        check("rst_ready", bus.tx_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rxdata", bus.rx_data, 0);
        repeat (3) @(posedge clk);
        #1 check("rst_ready_hold", bus.tx_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", bus.tx_ready, 1);

        // Single byte loopback, then a two-byte transaction through GAP.
        xfer(8'hA5, 1'b1, 1'b0);
        rises = 0;
        rxv_cnt = 0;
        xfer(8'h3C, 1'b0, 1'b0);
        xfer(8'hC3, 1'b1, 1'b0);
        check("two_byte_rises", rises, 16);
        check("two_byte_rxv", rxv_cnt, 2);

        loop_en = 1'b0;
        periph_byte = 8'h5A;
        xfer(8'hFF, 1'b1, 1'b0);
        loop_en = 1'b1;
        xfer(8'h69, 1'b1, 1'b1);

        // Reset at the 4th rising edge of a frame.
        rises = 0;
        rxv_cnt = 0;
        bus.tx_data  = 8'h96;
        bus.tx_last  = 1'b1;
        bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        bus.tx_valid = 1'b0;
        n = 0;
        while (rises < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_rise4", rises, 4);
        rst_n = 1'b0;
        #1;
        check("arst_ss", bus.ss, 1);
        check("arst_sclk", bus.sclk, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_ready", bus.tx_ready, 0);
        check("arst_rxdata", bus.rx_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("ready_pre_clk", bus.tx_ready, 0);
        @(posedge clk); #1;
        check("ready_post_rst", bus.tx_ready, 1);
        check("arst_no_rxv", rxv_cnt, 0);
        xfer(8'h81, 1'b1, 1'b0);

        // Randomized transactions of 1..3 bytes with random GAP dwell.
        repeat (6) begin
            loop_en = 1'($urandom);
            periph_byte = 8'($urandom);
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) begin
                if (b != 0) begin
                    repeat ($urandom_range(0, 3)) begin
                        check("gap_ready", bus.tx_ready, 1);
                        check("gap_ss", bus.ss, 0);
                        check("gap_sclk", bus.sclk, 0);
                        @(posedge clk); #1;
                    end
                    periph_byte = 8'($urandom);
                end
                xfer(8'($urandom), (b == nb - 1), 1'b0);
            end
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
